pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the MINI-RISC F/D/E/W pipeline.
- Generates stall_F/flush_F (FD register) and stall_D/flush_D (DE register), operand forwarding selects for Decode, and PC redirect on taken branches.
- Small FSM handles multi-cycle load-use stalls, branch-flush windows and halt/resume.

---
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller interface for the MINI-RISC F/D/E/W pipeline.
// Purpose: bundles the hazard-detection inputs and the stall/flush/forward/
// redirect outputs of pipe_hazard_ctrl into one interface.
// Modports:
//   master - pipeline side: drives the Decode/Execute/Writeback status and
//            halt/resume, and receives the control outputs
//   slave  - controller side (pipe_hazard_ctrl)
interface pipe_hazard_ctrl_if;
  logic [2:0]  rs1_D;
  logic [2:0]  rs2_D;
  logic        use_rs1_D;
  logic        use_rs2_D;
  logic [2:0]  rd_E;
  logic [1:0]  write_mode_E;
  logic        mem_read_E;
  logic [2:0]  rd_W;
  logic [1:0]  write_mode_W;
  logic        branch_taken_E;
  logic [10:0] branch_addr_E;
  logic        halt_req_D;
  logic        resume;

  logic        stall_F;
  logic        flush_F;
  logic        stall_D;
  logic        flush_D;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        pc_redirect;
  logic [10:0] pc_target;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output rs1_D, rs2_D, use_rs1_D, use_rs2_D, rd_E, write_mode_E, mem_read_E,
           rd_W, write_mode_W, branch_taken_E, branch_addr_E, halt_req_D, resume,
    input  stall_F, flush_F, stall_D, flush_D, fwd_a_sel, fwd_b_sel,
           pc_redirect, pc_target, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_D, rs2_D, use_rs1_D, use_rs2_D, rd_E, write_mode_E, mem_read_E,
           rd_W, write_mode_W, branch_taken_E, branch_addr_E, halt_req_D, resume,
    output stall_F, flush_F, stall_D, flush_D, fwd_a_sel, fwd_b_sel,
           pc_redirect, pc_target, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl - hazard and sequencing controller for the MINI-RISC
// F/D/E/W pipeline.
// Purpose: load-use stalls, branch flush windows with PC redirect, halt/resume,
// and Decode operand forwarding selects.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - pipe_hazard_ctrl_if.slave (hazard inputs, control outputs)
// Parameters:
//   LOAD_LAT   - cycles a dependent instruction is held after a load (1..7)
//   BR_PENALTY - cycles both pipeline registers are flushed on a taken branch (1..7)
// Optional feature macro: HAZ_PERF_CNT_EN enables the saturating stall/flush
// performance counters; without it stall_cnt/flush_cnt are tied to 0.
//
// state    | meaning
// RUN      | normal flow, hazards detected combinationally
// LD_STALL | holding a load-dependent instruction in Decode
// BR_FLUSH | flushing the wrong-path instructions behind a taken branch
// HALT     | pipeline frozen until resume or a taken branch
module pipe_hazard_ctrl #(
  parameter int LOAD_LAT   = 1,
  parameter int BR_PENALTY = 1
) (
  input logic              clk,
  input logic              reset_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, LD_STALL, BR_FLUSH, HALT} state_t;

  localparam logic [2:0] LD_CNT = 3'(LOAD_LAT - 1);
  localparam logic [2:0] BR_CNT = 3'(BR_PENALTY - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic dep_E, load_use, take_branch;
  logic stall_f_raw, flush_f_c, flush_d_c, redirect_c, halted_c;
  logic stall_f_o, flush_f_o;

  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [2:0] rs,
                                         input logic [2:0] rd_e, input logic [1:0] wm_e,
                                         input logic mem_e, input logic [2:0] rd_w,
                                         input logic [1:0] wm_w);
    // A load's data is not ready in E, so it can only be forwarded from W.
    if (use_rs && rs == rd_e && wm_e != 2'b00 && !mem_e)
      return 2'b01;
    else if (use_rs && rs == rd_w && wm_w != 2'b00)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign dep_E = (bus.write_mode_E != 2'b00) &&
                 ((bus.use_rs1_D && bus.rs1_D == bus.rd_E) ||
                  (bus.use_rs2_D && bus.rs2_D == bus.rd_E));
  assign load_use = bus.mem_read_E && dep_E;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_f_raw = 1'b0;
    flush_f_c   = 1'b0;
    flush_d_c   = 1'b0;
    redirect_c  = 1'b0;
    halted_c    = 1'b0;
    take_branch = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.branch_taken_E) begin
          take_branch = 1'b1;
        end else if (load_use) begin
          stall_f_raw = 1'b1;
          flush_d_c   = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LD_STALL;
            cnt_d   = LD_CNT;
          end
        end else if (bus.halt_req_D) begin
          stall_f_raw = 1'b1;
          flush_d_c   = 1'b1;
          state_d     = HALT;
        end
      end
      LD_STALL: begin
        if (bus.branch_taken_E) begin
          take_branch = 1'b1;
        end else begin
          stall_f_raw = 1'b1;
          flush_d_c   = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end
      end
      BR_FLUSH: begin
        // E holds a flushed bubble, so any branch_taken_E here is stale.
        flush_f_c = 1'b1;
        flush_d_c = 1'b1;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      end
      HALT: begin
        if (bus.branch_taken_E) begin
          take_branch = 1'b1;
        end else begin
          stall_f_raw = 1'b1;
          flush_d_c   = 1'b1;
          halted_c    = 1'b1;
          if (bus.resume) state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase

    if (take_branch) begin
      flush_f_c  = 1'b1;
      flush_d_c  = 1'b1;
      redirect_c = 1'b1;
      if (BR_PENALTY > 1) begin
        state_d = BR_FLUSH;
        cnt_d   = BR_CNT;
      end else begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are combinational, gated by reset_n so they drop the instant
  // reset is asserted. Flush beats stall on the FD register.
  assign flush_f_o = reset_n & flush_f_c;
  assign stall_f_o = reset_n & stall_f_raw & ~flush_f_c;

  assign bus.stall_F     = stall_f_o;
  assign bus.flush_F     = flush_f_o;
  assign bus.stall_D     = 1'b0;
  assign bus.flush_D     = reset_n & flush_d_c;
  assign bus.pc_redirect = reset_n & redirect_c;
  assign bus.pc_target   = (reset_n && redirect_c) ? bus.branch_addr_E : 11'd0;
  assign bus.halted      = reset_n & halted_c;
  assign bus.fwd_a_sel   = reset_n ? fwd_sel(bus.use_rs1_D, bus.rs1_D, bus.rd_E,
                                             bus.write_mode_E, bus.mem_read_E,
                                             bus.rd_W, bus.write_mode_W) : 2'b00;
  assign bus.fwd_b_sel   = reset_n ? fwd_sel(bus.use_rs2_D, bus.rs2_D, bus.rd_E,
                                             bus.write_mode_E, bus.mem_read_E,
                                             bus.rd_W, bus.write_mode_W) : 2'b00;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_f_o && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_f_o && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = 16'd0;
  assign bus.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // dut_a: LOAD_LAT=2, BR_PENALTY=2.  dut_b: LOAD_LAT=4, BR_PENALTY=1.
  pipe_hazard_ctrl_if bus_a();
  pipe_hazard_ctrl_if bus_b();

  pipe_hazard_ctrl #(.LOAD_LAT(2), .BR_PENALTY(2)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .bus(bus_a.slave));
  pipe_hazard_ctrl #(.LOAD_LAT(4), .BR_PENALTY(1)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .bus(bus_b.slave));

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {stall_F, flush_F, stall_D, flush_D, fwd_a, fwd_b, pc_redirect, pc_target, halted}
  function automatic logic [21:0] outs_a();
    return {bus_a.stall_F, bus_a.flush_F, bus_a.stall_D, bus_a.flush_D, bus_a.fwd_a_sel,
            bus_a.fwd_b_sel, bus_a.pc_redirect, bus_a.pc_target, bus_a.halted};
  endfunction

  function automatic logic [21:0] outs_b();
    return {bus_b.stall_F, bus_b.flush_F, bus_b.stall_D, bus_b.flush_D, bus_b.fwd_a_sel,
            bus_b.fwd_b_sel, bus_b.pc_redirect, bus_b.pc_target, bus_b.halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    bus_a.rs1_D = 3'd0; bus_a.rs2_D = 3'd0; bus_a.use_rs1_D = 1'b0; bus_a.use_rs2_D = 1'b0;
    bus_a.rd_E = 3'd0; bus_a.write_mode_E = 2'd0; bus_a.mem_read_E = 1'b0;
    bus_a.rd_W = 3'd0; bus_a.write_mode_W = 2'd0; bus_a.branch_taken_E = 1'b0;
    bus_a.branch_addr_E = 11'd0; bus_a.halt_req_D = 1'b0; bus_a.resume = 1'b0;
  endtask

  task automatic clear_b();
    bus_b.rs1_D = 3'd0; bus_b.rs2_D = 3'd0; bus_b.use_rs1_D = 1'b0; bus_b.use_rs2_D = 1'b0;
    bus_b.rd_E = 3'd0; bus_b.write_mode_E = 2'd0; bus_b.mem_read_E = 1'b0;
    bus_b.rd_W = 3'd0; bus_b.write_mode_W = 2'd0; bus_b.branch_taken_E = 1'b0;
    bus_b.branch_addr_E = 11'd0; bus_b.halt_req_D = 1'b0; bus_b.resume = 1'b0;
  endtask

  task automatic test_reset();
    clear_a();
    clear_b();
    // Drive hazards while in reset: outputs must still be 0.
    bus_a.branch_taken_E = 1'b1; bus_a.branch_addr_E = 11'h3FF;
    bus_a.rs1_D = 3'd2; bus_a.use_rs1_D = 1'b1; bus_a.rd_W = 3'd2; bus_a.write_mode_W = 2'd1;
    tick(); tick();
    checks++;
    if (outs_a() !== 22'd0) begin
      failures++; $display("FAIL reset_outs_low: got %h expected 0", outs_a());
    end
    checks++;
    if (bus_a.stall_cnt !== 16'd0 || bus_a.flush_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus_a.stall_cnt, bus_a.flush_cnt);
    end
    clear_a();
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    #1;
    tick();
    checks++;
    if (outs_a() !== 22'd0) begin
      failures++; $display("FAIL reset_idle_run: got %h expected 0", outs_a());
    end
  endtask

  task automatic test_load_use();
    bus_a.rd_E = 3'd5; bus_a.write_mode_E = 2'd1; bus_a.mem_read_E = 1'b1;
    bus_a.rs2_D = 3'd5; bus_a.use_rs2_D = 1'b1;
    #1;
    checks++;
    if ({bus_a.stall_F, bus_a.flush_D, bus_a.flush_F, bus_a.fwd_b_sel} !== 5'b11000) begin
      failures++; $display("FAIL load_use_c0: got %b expected 11000", {bus_a.stall_F, bus_a.flush_D, bus_a.flush_F, bus_a.fwd_b_sel});
    end
    tick();
    clear_a();
    #1;
    checks++;
    if ({bus_a.stall_F, bus_a.flush_D, bus_a.flush_F} !== 3'b110) begin
      failures++; $display("FAIL load_use_c1: got %b expected 110", {bus_a.stall_F, bus_a.flush_D, bus_a.flush_F});
    end
    tick();
    checks++;
    if (outs_a() !== 22'd0) begin
      failures++; $display("FAIL load_use_c2: got %h expected 0", outs_a());
    end
    checks++;
    if (bus_a.stall_cnt !== (PERF ? 16'd2 : 16'd0) || bus_a.flush_cnt !== 16'd0) begin
      failures++; $display("FAIL load_use_perf: got %0d/%0d expected %0d/0", bus_a.stall_cnt, bus_a.flush_cnt, PERF ? 2 : 0);
    end
  endtask

  task automatic test_forwarding();
    bus_a.rd_E = 3'd3; bus_a.write_mode_E = 2'b01; bus_a.mem_read_E = 1'b0;
    bus_a.rs1_D = 3'd3; bus_a.use_rs1_D = 1'b1; bus_a.rd_W = 3'd3; bus_a.write_mode_W = 2'b01;
    #1;
    checks++;
    if (bus_a.fwd_a_sel !== 2'b01 || bus_a.fwd_b_sel !== 2'b00) begin
      failures++; $display("FAIL fwd_e_beats_w: got a=%b b=%b expected a=01 b=00", bus_a.fwd_a_sel, bus_a.fwd_b_sel);
    end
    bus_a.write_mode_E = 2'b00;
    #1;
    checks++;
    if (bus_a.fwd_a_sel !== 2'b10) begin
      failures++; $display("FAIL fwd_w_only: got %b expected 10", bus_a.fwd_a_sel);
    end
    bus_a.use_rs1_D = 1'b0;
    bus_a.rs2_D = 3'd6; bus_a.use_rs2_D = 1'b1; bus_a.rd_E = 3'd6; bus_a.write_mode_E = 2'b10;
    #1;
    checks++;
    if (bus_a.fwd_a_sel !== 2'b00 || bus_a.fwd_b_sel !== 2'b01) begin
      failures++; $display("FAIL fwd_b_from_e: got a=%b b=%b expected a=00 b=01", bus_a.fwd_a_sel, bus_a.fwd_b_sel);
    end
    bus_a.rd_W = 3'd6; bus_a.write_mode_W = 2'b00; bus_a.write_mode_E = 2'b00;
    #1;
    checks++;
    if (bus_a.fwd_b_sel !== 2'b00 || bus_a.stall_F !== 1'b0) begin
      failures++; $display("FAIL fwd_none: got b=%b stall=%b expected 00/0", bus_a.fwd_b_sel, bus_a.stall_F);
    end
    clear_a();
    tick();
  endtask

  task automatic test_branch();
    bus_a.branch_taken_E = 1'b1; bus_a.branch_addr_E = 11'h123;
    #1;
    checks++;
    if ({bus_a.pc_redirect, bus_a.pc_target, bus_a.flush_F, bus_a.flush_D, bus_a.stall_F} !== {1'b1, 11'h123, 3'b110}) begin
      failures++; $display("FAIL branch_c0: got r=%b t=%h fF=%b fD=%b sF=%b expected 1 123 1 1 0",
                           bus_a.pc_redirect, bus_a.pc_target, bus_a.flush_F, bus_a.flush_D, bus_a.stall_F);
    end
    tick();
    // A stale branch in the flushed E slot must be ignored.
    bus_a.branch_addr_E = 11'h055;
    #1;
    checks++;
    if ({bus_a.pc_redirect, bus_a.pc_target, bus_a.flush_F, bus_a.flush_D} !== {1'b0, 11'h000, 2'b11}) begin
      failures++; $display("FAIL branch_c1: got r=%b t=%h fF=%b fD=%b expected 0 000 1 1",
                           bus_a.pc_redirect, bus_a.pc_target, bus_a.flush_F, bus_a.flush_D);
    end
    tick();
    clear_a();
    #1;
    checks++;
    if (outs_a() !== 22'd0) begin
      failures++; $display("FAIL branch_c2: got %h expected 0", outs_a());
    end
    checks++;
    if (bus_a.flush_cnt !== (PERF ? 16'd2 : 16'd0)) begin
      failures++; $display("FAIL branch_perf: got %0d expected %0d", bus_a.flush_cnt, PERF ? 2 : 0);
    end
  endtask

  task automatic test_load_and_branch();
    bus_a.rd_E = 3'd4; bus_a.write_mode_E = 2'd1; bus_a.mem_read_E = 1'b1;
    bus_a.rs1_D = 3'd4; bus_a.use_rs1_D = 1'b1;
    bus_a.branch_taken_E = 1'b1; bus_a.branch_addr_E = 11'h2AA;
    #1;
    checks++;
    if ({bus_a.stall_F, bus_a.flush_F, bus_a.pc_redirect, bus_a.pc_target} !== {3'b011, 11'h2AA}) begin
      failures++; $display("FAIL ldbr_c0: got sF=%b fF=%b r=%b t=%h expected 0 1 1 2aa",
                           bus_a.stall_F, bus_a.flush_F, bus_a.pc_redirect, bus_a.pc_target);
    end
    tick();
    clear_a();
    #1;
    checks++;
    if ({bus_a.stall_F, bus_a.flush_F, bus_a.flush_D} !== 3'b011) begin
      failures++; $display("FAIL ldbr_c1_no_ldstall: got %b expected 011", {bus_a.stall_F, bus_a.flush_F, bus_a.flush_D});
    end
    tick();
    checks++;
    if (outs_a() !== 22'd0) begin
      failures++; $display("FAIL ldbr_c2: got %h expected 0", outs_a());
    end
  endtask

  task automatic test_halt();
    bus_a.halt_req_D = 1'b1;
    #1;
    checks++;
    if ({bus_a.stall_F, bus_a.flush_D, bus_a.halted} !== 3'b110) begin
      failures++; $display("FAIL halt_enter: got %b expected 110", {bus_a.stall_F, bus_a.flush_D, bus_a.halted});
    end
    tick();
    bus_a.halt_req_D = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({bus_a.halted, bus_a.stall_F, bus_a.flush_D, bus_a.flush_F} !== 4'b1110) begin
        failures++; $display("FAIL halt_hold[%0d]: got %b expected 1110", i, {bus_a.halted, bus_a.stall_F, bus_a.flush_D, bus_a.flush_F});
      end
      tick();
    end
    bus_a.resume = 1'b1;
    tick();
    bus_a.resume = 1'b0;
    #1;
    checks++;
    if (outs_a() !== 22'd0) begin
      failures++; $display("FAIL halt_resume: got %h expected 0", outs_a());
    end
    // Halt again, then leave it through a taken branch.
    bus_a.halt_req_D = 1'b1;
    tick();
    bus_a.halt_req_D = 1'b0;
    bus_a.branch_taken_E = 1'b1; bus_a.branch_addr_E = 11'h07C;
    #1;
    checks++;
    if ({bus_a.pc_redirect, bus_a.pc_target, bus_a.flush_F, bus_a.stall_F} !== {1'b1, 11'h07C, 2'b10}) begin
      failures++; $display("FAIL halt_branch: got r=%b t=%h fF=%b sF=%b expected 1 07c 1 0",
                           bus_a.pc_redirect, bus_a.pc_target, bus_a.flush_F, bus_a.stall_F);
    end
    tick();
    clear_a();
    tick();
    checks++;
    if (outs_a() !== 22'd0) begin
      failures++; $display("FAIL halt_branch_exit: got %h expected 0", outs_a());
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_b();
    bus_b.rd_E = 3'd1; bus_b.write_mode_E = 2'd3; bus_b.mem_read_E = 1'b1;
    bus_b.rs1_D = 3'd1; bus_b.use_rs1_D = 1'b1;
    tick();
    clear_b();
    tick();
    // LD_STALL with cnt=2
    checks++;
    if ({bus_b.stall_F, bus_b.flush_D} !== 2'b11) begin
      failures++; $display("FAIL midstall_pre: got %b expected 11", {bus_b.stall_F, bus_b.flush_D});
    end
    bus_b.rs1_D = 3'd7; bus_b.use_rs1_D = 1'b1; bus_b.rd_W = 3'd7; bus_b.write_mode_W = 2'd1;
    rst_b_n = 1'b0;
    #1;
    checks++;
    if (outs_b() !== 22'd0) begin
      failures++; $display("FAIL midstall_reset: got %h expected 0", outs_b());
    end
    tick();
    clear_b();
    rst_b_n = 1'b1;
    #1;
    checks++;
    if (outs_b() !== 22'd0) begin
      failures++; $display("FAIL midstall_release: got %h expected 0", outs_b());
    end
    tick();
    checks++;
    if (outs_b() !== 22'd0) begin
      failures++; $display("FAIL midstall_no_residual: got %h expected 0", outs_b());
    end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_load_and_branch();
        test_halt();
        test_reset_mid_stall();
      end
      begin
        #20000;
        failures++;
        $display("FAIL timeout: got no completion expected done by 20000");
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
